// File: rtl/f_position_decoder.sv
// f_position_decoder: leading-one position decoder/normalizer; F_POS_DECODER_ZERO_DETECT_EN enables zero-mantissa bypass
module f_position_decoder #(
   parameter int STEP   = 4,
   parameter int MANT_W = 23,
   parameter int EXP_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [4:0]        i_pos,
   input  logic [MANT_W-1:0] i_mant_in,
   input  logic [EXP_W-1:0]  i_exp_in,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [MANT_W-1:0] o_mant_out,
   output logic [EXP_W-1:0]  o_exp_out,
   output logic [MANT_W-1:0] o_onehot,
   output logic              o_uflow,
   output logic              o_pos_err,
   output logic              o_zero
);
   localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
   localparam logic [4:0] MAXP = 5'(MANT_W - 1);
   logic [1:0]        r_state;
   logic [4:0]        r_rem;
   logic [MANT_W-1:0] r_mant, r_onehot;
   logic [EXP_W-1:0]  r_exp;
   logic              r_uflow, r_pos_err, r_zero;
   logic [4:0]        w_eff, w_d;
   logic              w_under, w_zero_in;
   assign w_eff   = (i_pos > MAXP) ? MAXP : i_pos;
   assign w_d     = (r_rem > 5'(STEP)) ? 5'(STEP) : r_rem;
   assign w_under = i_exp_in < EXP_W'(w_eff);
`ifdef F_POS_DECODER_ZERO_DETECT_EN
   assign w_zero_in = (i_mant_in == '0);
`else
   assign w_zero_in = 1'b0;
`endif
   assign o_in_ready  = i_rst_n && r_state == S_IDLE;
   assign o_out_valid = i_rst_n && r_state == S_DONE;
   assign o_mant_out  = r_mant;
   assign o_exp_out   = r_exp;
   assign o_onehot    = r_onehot;
   assign o_uflow     = r_uflow;
   assign o_pos_err   = r_pos_err;
   assign o_zero      = r_zero;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_rem     <= '0;
         r_mant    <= '0;
         r_exp     <= '0;
         r_onehot  <= '0;
         r_uflow   <= 1'b0;
         r_pos_err <= 1'b0;
         r_zero    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_in_valid) begin
               r_zero    <= w_zero_in;
               r_pos_err <= !w_zero_in && i_pos > MAXP;
               r_onehot  <= w_zero_in ? '0 : MANT_W'(1) << (MAXP - w_eff);
               r_mant    <= i_mant_in;
               r_rem     <= w_zero_in ? 5'd0 : w_eff;
               r_uflow   <= !w_zero_in && w_under;
               r_exp     <= (w_zero_in || w_under) ? '0 : i_exp_in - EXP_W'(w_eff);
               r_state   <= (w_zero_in || w_eff == 5'd0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
               r_mant  <= r_mant << w_d;
               r_rem   <= r_rem - w_d;
               r_state <= (r_rem == w_d) ? S_DONE : S_SHIFT;
            end
            S_DONE:  if (i_out_ready) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_f_position_decoder.sv
// tb_f_position_decoder: directed and random transactions against an arithmetic normalization model
module tb_f_position_decoder;
   localparam int STEP = 4;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [4:0]  pos = '0;
   logic [22:0] mant_in = '0;
   logic [7:0]  exp_in = '0;
   logic        in_ready, out_valid, uflow, pos_err, zero;
   logic [22:0] mant_out, onehot;
   logic [7:0]  exp_out;
   int          n_assert = 0, n_fail = 0;

   f_position_decoder #(.STEP(STEP), .MANT_W(23), .EXP_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_pos(pos), .i_mant_in(mant_in), .i_exp_in(exp_in), .o_out_valid(out_valid),
      .i_out_ready(out_ready), .o_mant_out(mant_out), .o_exp_out(exp_out),
      .o_onehot(onehot), .o_uflow(uflow), .o_pos_err(pos_err), .o_zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic xact(input logic [4:0] p, input logic [22:0] m, input logic [7:0] e, input int hold);
      logic [31:0] eff, emant, eexp, eoh, euf, eerr, ezero, elat;
      logic [22:0] smant;
      logic [7:0]  sexp;
      int lat;
      eff   = (p > 22) ? 32'd22 : 32'(p);
      eerr  = 32'(p > 22);
      emant = (32'(m) << eff) & 32'h7FFFFF;
      euf   = 32'(32'(e) < eff);
      eexp  = euf[0] ? 32'd0 : 32'(e) - eff;
      eoh   = 32'h400000 >> eff;
      elat  = (eff + STEP - 1) / STEP;
      ezero = 0;
`ifdef F_POS_DECODER_ZERO_DETECT_EN
      if (m == 0) begin
         emant = 0; eexp = 0; eoh = 0; euf = 0; eerr = 0; ezero = 1; elat = 0;
      end
`endif
      chk("in_ready_idle", 32'(in_ready), 1);
      in_valid = 1'b1; pos = p; mant_in = m; exp_in = e;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; pos = 5'($urandom); mant_in = 23'($urandom); exp_in = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), elat);
      chk("mant_out", 32'(mant_out), emant);
      chk("exp_out", 32'(exp_out), eexp);
      chk("onehot", 32'(onehot), eoh);
      chk("uflow", 32'(uflow), euf);
      chk("pos_err", 32'(pos_err), eerr);
      chk("zero", 32'(zero), ezero);
      smant = mant_out; sexp = exp_out;
      repeat (hold) begin
         in_valid = 1'b1; pos = 5'd1; mant_in = 23'h1; exp_in = 8'd3;
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_ready", 32'(in_ready), 0);
         chk("hold_mant", 32'(mant_out), 32'(smant));
         chk("hold_exp", 32'(exp_out), 32'(sexp));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", 32'(out_valid), 0);
      chk("onehot_kept", 32'(onehot), eoh);
   endtask

   initial begin
      in_valid = 1'b1; pos = 5'd5; mant_in = 23'h0200A5; exp_in = 8'd100;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_mant", 32'(mant_out), 0);
      chk("rst_exp", 32'(exp_out), 0);
      chk("rst_onehot", 32'(onehot), 0);
      chk("rst_flags", {29'd0, uflow, pos_err, zero}, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", 32'(in_ready), 1);
      xact(5'd5, 23'h0200A5, 8'd100, 0);
      xact(5'd0, 23'h400001, 8'd7, 0);
      xact(5'd22, 23'h000001, 8'd10, 0);
      xact(5'd27, 23'h000001, 8'd50, 5);
      xact(5'd3, 23'h000000, 8'd9, 0);
      in_valid = 1'b1; pos = 5'd22; mant_in = 23'h1; exp_in = 8'd40;
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_mant", 32'(mant_out), 0);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("abort_no_result", 32'(out_valid), 0);
      end
      for (int i = 0; i < 40; i++)
         xact(5'($urandom_range(0, 31)),
              ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom),
              8'($urandom), int'($urandom_range(0, 2)));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
